// File: rtl/multiplicador_secuencial_ctrl_pkg.sv
// Common types and default parameters for the shift-and-add multiplier.
package multiplicador_secuencial_ctrl_pkg;
`include "multiplicador_defs.vh"

    localparam int MULT_N  = `MULT_N_DEFAULT;
    localparam int MULT_CW = `MULT_CW_DEFAULT;

    typedef enum logic [1:0] {
        S_IDLE = `ST_IDLE,
        S_RUN  = `ST_RUN,
        S_DONE = `ST_DONE
    } state_t;

endpackage

// File: rtl/multiplicador_defs.vh
// Shared state encodings and default sizing for the sequential multiplier family.
`ifndef MULTIPLICADOR_DEFS_VH
`define MULTIPLICADOR_DEFS_VH

`define ST_IDLE 2'd0
`define ST_RUN  2'd1
`define ST_DONE 2'd2

`define MULT_N_DEFAULT  4
`define MULT_CW_DEFAULT 3

`endif

// File: rtl/multiplicador_secuencial_dp.sv
// Datapath: multiplicand register, {C,acc,Q} shift register, 1-bit multiplier cells and adder.
module multiplicador_secuencial_dp
    import multiplicador_secuencial_ctrl_pkg::*;
#(
    parameter int N = MULT_N
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load_i,
    input  logic           step_i,
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] prod_cur_o,
    output logic [2*N-1:0] prod_next_o
);

    logic [N-1:0] areg_q, areg_d;
    logic [N-1:0] acc_q, acc_d;
    logic [N-1:0] q_q, q_d;
    logic         c_q, c_d;
    logic [N-1:0] pp;
    logic [N:0]   sum;

    // One 1-bit multiplier cell per multiplicand bit, all selected by Q[0].
    for (genvar gi = 0; gi < N; gi++) begin : g_cell
        assign pp[gi] = q_q[0] ? areg_q[gi] : 1'b0;
    end

    assign sum = {c_q, acc_q} + {1'b0, pp};

    always_comb begin
        areg_d = areg_q;
        acc_d  = acc_q;
        q_d    = q_q;
        c_d    = c_q;
        if (load_i) begin
            areg_d = a_i;
            acc_d  = '0;
            q_d    = b_i;
            c_d    = 1'b0;
        end else if (step_i) begin
            {c_d, acc_d, q_d} = {sum, q_q} >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            areg_q <= '0;
            acc_q  <= '0;
            q_q    <= '0;
            c_q    <= 1'b0;
        end else begin
            areg_q <= areg_d;
            acc_q  <= acc_d;
            q_q    <= q_d;
            c_q    <= c_d;
        end
    end

    assign prod_cur_o  = {acc_q, q_q};
    // {acc,Q} as it will be after this cycle's add-and-shift.
    assign prod_next_o = {sum, q_q[N-1:1]};

endmodule

// File: rtl/multiplicador_secuencial_ctrl.sv
// Sequential N x N multiplier controller: FSM, iteration counter, handshake and product register.
// Optional early termination on exhausted multiplier bits: define MULT_EARLY_DONE_EN.
module multiplicador_secuencial_ctrl
    import multiplicador_secuencial_ctrl_pkg::*;
#(
    parameter int N  = MULT_N,
    parameter int CW = MULT_CW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] P
);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]  p_q, p_d;
    logic [2*N-1:0]  prod_cur;
    logic [2*N-1:0]  prod_next;
    logic            load;
    logic            step;
    logic            early_skip;

    multiplicador_secuencial_dp #(
        .N(N)
    ) u_dp (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load),
        .step_i     (step),
        .a_i        (A),
        .b_i        (B),
        .prod_cur_o (prod_cur),
        .prod_next_o(prod_next)
    );

`ifdef MULT_EARLY_DONE_EN
    logic [N-1:0] low_mask;
    // Q[cnt-1:0] holds the multiplier bits not yet consumed.
    assign low_mask   = ~({N{1'b1}} << cnt_q);
    assign early_skip = (state_q == S_RUN) && ((prod_cur[N-1:0] & low_mask) == '0);
`else
    logic unused_prod_cur;
    assign unused_prod_cur = ^prod_cur;
    assign early_skip      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = CW'(N);
                end
            end
            S_RUN: begin
`ifdef MULT_EARLY_DONE_EN
                // Remaining iterations would only shift: align in one step.
                if (early_skip) begin
                    p_d     = prod_cur >> cnt_q;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else
`endif
                begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        p_d     = prod_next;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
        load = (state_q == S_IDLE) && start;
        step = (state_q == S_RUN) && !early_skip;
    end

    assign P = p_q;

endmodule
